gauss_win_sched: RTL and testbench

// Raster-scan scheduler for the 3x3 RGB Gaussian convolution stage (conv_9).
// - Accepts a pixel stream and keeps two previous rows in a line buffer.
// - Builds the 27-byte RGB window and drives conv_9.start_conv as the pipeline-advance strobe.
// - Tracks validity through conv_9's 2-register pipeline, applies backpressure, flushes at frame end.
// - Emits out_valid/out_x/out_y/out_last for each conv_9.output_word.

---
 rtl/gauss_pkg.sv | 20 ++
 rtl/conv_line_buf.sv | 32 +++
 rtl/gauss_win_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_gauss_win_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared definitions for the 3x3 RGB Gaussian window scheduler.
//   state_e : scheduler FSM states
//   PIX_W   : packed {R,G,B} pixel width
//   WIN_W   : one colour lane of a 3x3 window (9 bytes)
//   LB_W    : line-buffer word, {row y-2, row y-1} pixels
package gauss_pkg;

   localparam int unsigned PIX_W = 24;
   localparam int unsigned WIN_W = 72;
   localparam int unsigned LB_W  = 2 * PIX_W;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StFlush,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/conv_line_buf.sv
// Two-row line buffer for the Gaussian window scheduler.
// One entry per image column, holding {older row, newer row} pixels.
//   clk        : clock
//   wr_en_i    : write rd/wr column addr_i with wr_data_i
//   addr_i     : column index
//   wr_data_i  : {row y-1, row y} pixel pair to store
//   rd_data_o  : {row y-2, row y-1} pixel pair, combinational read
module conv_line_buf
   import gauss_pkg::*;
#(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = 10
) (
   input  logic            clk,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [LB_W-1:0] wr_data_i,
   output logic [LB_W-1:0] rd_data_o
);

   // Contents are don't-care after reset; rows 0/1 reads are masked downstream.
   logic [LB_W-1:0] mem_q [DEPTH];

   assign rd_data_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[addr_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/gauss_win_sched.sv
// Raster-scan scheduler feeding a 3x3 RGB Gaussian convolver (conv_9).
// Buffers two rows, builds the 3x3 window, strobes start_conv_o to advance
// the convolver's two-register pipeline, and tracks which output words hold
// valid interior results.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : frame start, honoured only when idle
//   in_valid_i/in_ready_o/in_pix_i : raster-order {R,G,B} pixel stream
//   start_conv_o    : convolver pipeline-advance strobe
//   win_r_o/g_o/b_o : window lanes, element (0,0) in the top byte
//   out_valid_o/out_ready_i : convolver output word handshake
//   out_x_o/out_y_o : window centre of the current output word
//   out_last_o      : current output is the final centre of the frame
//   busy_o          : not idle
//   frame_done_o    : single-cycle pulse once the last output is taken
module gauss_win_sched
   import gauss_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned CW    = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             in_valid_i,
   input  logic [PIX_W-1:0] in_pix_i,
   output logic             in_ready_o,
   output logic             start_conv_o,
   output logic [WIN_W-1:0] win_r_o,
   output logic [WIN_W-1:0] win_g_o,
   output logic [WIN_W-1:0] win_b_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [CW-1:0]    out_x_o,
   output logic [CW-1:0]    out_y_o,
   output logic             out_last_o,
   output logic             busy_o,
   output logic             frame_done_o
);

   localparam logic [CW-1:0] XMax = CW'(IMG_W - 1);
   localparam logic [CW-1:0] YMax = CW'(IMG_H - 1);
   localparam int unsigned   LbAw = $clog2(IMG_W);

   state_e          state_q;
   logic [CW-1:0]   x_q, y_q;
   logic            fcnt_q;
   logic            frame_done_q;

   // Window pixels, [row][col]; row 0 / col 0 are the oldest.
   logic [PIX_W-1:0] win_q [3][3];

   // Validity/coordinate pipeline mirroring window -> conv_temp -> output_word.
   logic            s0_q, s1_q;
   logic [CW-1:0]   tag0_x_q, tag0_y_q, tag1_x_q, tag1_y_q;
   logic            tag0_last_q, tag1_last_q;
   logic            out_valid_q, out_last_q;
   logic [CW-1:0]   out_x_q, out_y_q;

   logic            in_run, in_flush, stall, accept, adv;
   logic [LB_W-1:0] lb_rd;
   logic [PIX_W-1:0] lb_old, lb_mid;

   assign in_run   = (state_q == StRun);
   assign in_flush = (state_q == StFlush);
   assign stall    = out_valid_q && !out_ready_i;
   assign accept   = in_run && in_valid_i && !stall;
   assign adv      = !stall && ((in_run && in_valid_i) || in_flush);

   assign start_conv_o = adv;
   assign in_ready_o   = in_run && !stall;
   assign busy_o       = (state_q != StIdle);
   assign frame_done_o = frame_done_q;
   assign out_valid_o  = out_valid_q;
   assign out_x_o      = out_x_q;
   assign out_y_o      = out_y_q;
   assign out_last_o   = out_last_q;

   assign lb_old = lb_rd[LB_W-1:PIX_W];
   assign lb_mid = lb_rd[PIX_W-1:0];

   conv_line_buf #(
      .DEPTH (IMG_W),
      .AW    (LbAw)
   ) u_line_buf (
      .clk       (clk),
      .wr_en_i   (accept),
      .addr_i    (x_q[LbAw-1:0]),
      .wr_data_i ({lb_mid, in_pix_i}),
      .rd_data_o (lb_rd)
   );

   // Frame sequencing FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         fcnt_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q <= StRun;
                  x_q     <= '0;
                  y_q     <= '0;
               end
            end
            StRun: begin
               if (accept) begin
                  if (x_q == XMax) begin
                     x_q <= '0;
                     if (y_q == YMax) begin
                        state_q <= StFlush;
                        fcnt_q  <= 1'b0;
                     end else begin
                        y_q <= y_q + 1'b1;
                     end
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end
            end
            StFlush: begin
               // Two bubbles push the last window through conv_temp to output_word.
               if (adv) begin
                  if (fcnt_q) begin
                     state_q <= StDrain;
                  end else begin
                     fcnt_q <= 1'b1;
                  end
               end
            end
            StDrain: begin
               if (!out_valid_q || out_ready_i) begin
                  state_q      <= StDone;
                  frame_done_q <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Window shift registers and valid/tag pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
         s0_q        <= 1'b0;
         s1_q        <= 1'b0;
         tag0_x_q    <= '0;
         tag0_y_q    <= '0;
         tag0_last_q <= 1'b0;
         tag1_x_q    <= '0;
         tag1_y_q    <= '0;
         tag1_last_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 2; c++) begin
                  win_q[r][c] <= win_q[r][c+1];
               end
            end
            win_q[0][2] <= lb_old;
            win_q[1][2] <= lb_mid;
            win_q[2][2] <= in_pix_i;
            // x>=2 masks stale columns from the previous row; y>=2 masks rows 0/1.
            s0_q        <= (x_q >= CW'(2)) && (y_q >= CW'(2));
            tag0_x_q    <= x_q - 1'b1;
            tag0_y_q    <= y_q - 1'b1;
            tag0_last_q <= (x_q == XMax) && (y_q == YMax);
         end else if (adv) begin
            s0_q <= 1'b0;
         end

         if (adv) begin
            s1_q        <= s0_q;
            tag1_x_q    <= tag0_x_q;
            tag1_y_q    <= tag0_y_q;
            tag1_last_q <= tag0_last_q;
            out_valid_q <= s1_q;
            out_x_q     <= tag1_x_q;
            out_y_q     <= tag1_y_q;
            out_last_q  <= s1_q && tag1_last_q;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end

   // Lane packing: element (r,c) at byte index 3*r+c counted from the top.
   always_comb begin
      win_r_o = '0;
      win_g_o = '0;
      win_b_o = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_r_o[WIN_W-1-8*(3*r+c) -: 8] = win_q[r][c][23:16];
            win_g_o[WIN_W-1-8*(3*r+c) -: 8] = win_q[r][c][15:8];
            win_b_o[WIN_W-1-8*(3*r+c) -: 8] = win_q[r][c][7:0];
         end
      end
   end

endmodule

// File: tb/tb_gauss_win_sched.sv
// Directed bench for gauss_win_sched on a 5x4 frame with a behavioural
// 3x3 Gaussian convolver (two registers advanced by start_conv) attached.
module tb_gauss_win_sched;

   localparam int unsigned W  = 5;
   localparam int unsigned H  = 4;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [23:0]   in_pix = '0;
   logic          in_ready, start_conv;
   logic [71:0]   win_r, win_g, win_b;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] out_x, out_y;
   logic          out_last, busy, frame_done;

   always #5 clk = ~clk;

   gauss_win_sched #(
      .IMG_W (W),
      .IMG_H (H),
      .CW    (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .in_valid_i   (in_valid),
      .in_pix_i     (in_pix),
      .in_ready_o   (in_ready),
      .start_conv_o (start_conv),
      .win_r_o      (win_r),
      .win_g_o      (win_g),
      .win_b_o      (win_b),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_x_o      (out_x),
      .out_y_o      (out_y),
      .out_last_o   (out_last),
      .busy_o       (busy),
      .frame_done_o (frame_done)
   );

   // Convolver model: weights 1 2 1 / 2 4 2 / 1 2 1, sum >> 4.
   function automatic logic [7:0] gauss(input logic [71:0] w);
      int s = 0;
      for (int i = 0; i < 9; i++) begin
         s += ((i / 3 == 1) ? 2 : 1) * ((i % 3 == 1) ? 2 : 1) * int'(w[71-8*i -: 8]);
      end
      return 8'(s >> 4);
   endfunction

   logic [23:0] conv_temp, conv_word;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_temp <= '0;
         conv_word <= '0;
      end else if (start_conv) begin
         conv_temp <= {gauss(win_r), gauss(win_g), gauss(win_b)};
         conv_word <= conv_temp;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Output/strobe monitor, sampling pre-edge values.
   logic [23:0]   q_word[$];
   logic [CW-1:0] q_x[$];
   logic [CW-1:0] q_y[$];
   logic          q_last[$];
   int sc_cnt = 0, acc_cnt = 0, fd_cnt = 0;

   always @(posedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            q_word.push_back(conv_word);
            q_x.push_back(out_x);
            q_y.push_back(out_y);
            q_last.push_back(out_last);
         end
         if (start_conv) sc_cnt++;
         if (in_valid && in_ready) acc_cnt++;
         if (frame_done) fd_cnt++;
      end
   end

   // Backpressure driver: once armed, hold out_ready low for 5 cycles at the first out_valid.
   logic bp_arm = 1'b0;
   int   bp_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (bp_cnt > 0) begin
         bp_cnt--;
         if (bp_cnt == 0) out_ready = 1'b1;
      end else if (bp_arm && out_valid) begin
         out_ready = 1'b0;
         bp_arm    = 1'b0;
         bp_cnt    = 5;
      end
   end

   // While stalled: nothing advances and the output word is held.
   logic          hold_valid = 1'b0;
   logic [23:0]   hold_word;
   logic [CW-1:0] hold_x, hold_y;
   int            stall_cycles = 0;
   always @(negedge clk) begin
      if (rst_n && !out_ready) begin
         if (!hold_valid) begin
            hold_word  = conv_word;
            hold_x     = out_x;
            hold_y     = out_y;
            hold_valid = 1'b1;
         end else begin
            check("stall_word", 32'(conv_word), 32'(hold_word));
            check("stall_x", 32'(out_x), 32'(hold_x));
            check("stall_y", 32'(out_y), 32'(hold_y));
         end
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_start_conv", 32'(start_conv), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         stall_cycles++;
      end
   end

   function automatic logic [23:0] pix(input int mode, input int x, input int y);
      if (mode == 0) return 24'h101010;
      return {8'(x + 5 * y), 16'h0000};
   endfunction

   // Called at a negedge; returns at a negedge after the pixel was accepted.
   task automatic send(input logic [23:0] p, input int gap);
      int n = 0;
      in_valid = 1'b1;
      in_pix   = p;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic clear_q();
      q_word.delete();
      q_x.delete();
      q_y.delete();
      q_last.delete();
   endtask

   task automatic run_frame(input string tag, input int mode, input int gap, input int poke_at);
      int fd0 = fd_cnt;
      int sc0 = sc_cnt;
      int ac0 = acc_cnt;
      int n   = 0;
      int cx, cy;
      clear_q();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W * H; i++) begin
         send(pix(mode, i % W, i / W), gap);
         if (i == poke_at) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_poke_busy"}, 32'(busy), 32'd1);
            check({tag, "_poke_x"}, 32'(dut.x_q), 32'((i + 1) % W));
            check({tag, "_poke_y"}, 32'(dut.y_q), 32'((i + 1) / W));
         end
      end
      while (!frame_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(frame_done), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_done_count"}, 32'(fd_cnt - fd0), 32'd1);
      check({tag, "_starts"}, 32'(sc_cnt - sc0), 32'(W * H + 2));
      check({tag, "_accepts"}, 32'(acc_cnt - ac0), 32'(W * H));
      check({tag, "_n_out"}, 32'(q_word.size()), 32'((W - 2) * (H - 2)));
      for (int i = 0; i < q_word.size() && i < (W - 2) * (H - 2); i++) begin
         cx = 1 + i % (W - 2);
         cy = 1 + i / (W - 2);
         check({tag, "_out_x"}, 32'(q_x[i]), 32'(cx));
         check({tag, "_out_y"}, 32'(q_y[i]), 32'(cy));
         check({tag, "_out_last"}, 32'(q_last[i]), 32'(i == (W - 2) * (H - 2) - 1));
         check({tag, "_out_word"}, 32'(q_word[i]), 32'(pix(mode, cx, cy)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [71:0] exp_win;
   int          fd_before;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_start_conv", 32'(start_conv), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_win_r", 32'(win_r[71:40]), 32'd0);
      check("rst_out_xy", 32'({out_x, out_y, out_last}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Input offered while idle is not taken.
      in_valid = 1'b1;
      in_pix   = 24'hABCDEF;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_start_conv", 32'(start_conv), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);

      run_frame("const", 0, 0, -1);
      exp_win = {9{8'h10}};
      check("const_win_r_hi", 32'(exp_win[71:40]), 32'(win_r[71:40]));
      check("const_win_b_lo", 32'(win_b[31:0]), 32'(exp_win[31:0]));

      run_frame("ramp", 1, 0, -1);
      // Final window: rows y=1..3, columns x=2..4, R = x + 5y.
      exp_win = 72'h07_08_09_0C_0D_0E_11_12_13;
      check("ramp_win_r_hi", 32'(win_r[71:40]), 32'(exp_win[71:40]));
      check("ramp_win_r_lo", 32'(win_r[39:0]), 32'(exp_win[39:0]));
      check("ramp_win_g", 32'(win_g[71:40]), 32'd0);

      bp_arm       = 1'b1;
      hold_valid   = 1'b0;
      stall_cycles = 0;
      run_frame("bp", 1, 0, -1);
      check("bp_stall_cycles", 32'(stall_cycles), 32'd5);

      run_frame("gap", 1, 3, -1);

      // Reset in the middle of a frame.
      fd_before = fd_cnt;
      clear_q();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) send(pix(0, i % W, i / W), 0);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd0);
      check("mrst_x", 32'(dut.x_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_no_done", 32'(fd_cnt - fd_before), 32'd0);
      check("mrst_no_out", 32'(q_word.size()), 32'd0);
      run_frame("after_rst", 0, 0, -1);

      run_frame("poke", 0, 0, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
